// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and constants for the pipeline stall controller.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {S_RUN, S_MEMWAIT, S_ERR} state_t;
  localparam logic [4:0] REG_ZERO = 5'h00;
endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: saturating event counter, cleared by synchronous reset.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush/bubble sequencing for load-use, taken branches and dmem waits.
// Define PIPE_PERF_CNT_EN to build the stall/flush/memwait performance counters.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemReadE,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic             PCSrcE,
  input  logic             MemAccM,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             BubbleW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cyc,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cyc
);
  localparam int WAIT_W = $clog2(MAX_WAIT);
  state_t state;
  logic [WAIT_W-1:0] wait_cnt;
  logic err_q, lu, mw, res, hold, flush, ldst;
  assign lu = MemReadE && RD_E != REG_ZERO && (RD_E == Rs1_D || RD_E == Rs2_D);
  assign mw = MemAccM && !dmem_ready;
  // res: cycles in which branch/load-use hazards in E are allowed to resolve
  assign res   = !rst && ((state == S_RUN && !mw) || (state == S_MEMWAIT && dmem_ready));
  assign hold  = !rst && ((state == S_RUN && mw) || (state == S_MEMWAIT && !dmem_ready) || state == S_ERR);
  assign flush = res && PCSrcE;
  assign ldst  = res && !PCSrcE && lu;
  assign StallF  = hold || ldst;
  assign StallD  = hold || ldst;
  assign StallE  = hold;
  assign StallM  = hold;
  assign FlushD  = flush;
  assign FlushE  = flush || ldst;
  assign BubbleW = hold;
  assign mem_err = !rst && err_q;
  always_ff @(posedge clk)
    if (rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else
      case (state)
        S_RUN:
          if (mw) begin
            state    <= S_MEMWAIT;
            wait_cnt <= WAIT_W'(1);
          end
        S_MEMWAIT:
          if (dmem_ready) begin
            state    <= S_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
            state <= S_ERR;
            err_q <= 1'b1;
          end else wait_cnt <= wait_cnt + 1'b1;
        S_ERR: state <= S_ERR;
        default: state <= S_RUN;
      endcase
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] sc, fc, mc;
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall (.clk(clk), .rst(rst), .inc(StallF), .cnt(sc));
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush (.clk(clk), .rst(rst), .inc(FlushD), .cnt(fc));
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_mwait (.clk(clk), .rst(rst), .inc(state == S_MEMWAIT), .cnt(mc));
  assign stall_cyc   = rst ? '0 : sc;
  assign flush_cnt   = rst ? '0 : fc;
  assign memwait_cyc = rst ? '0 : mc;
`else
  assign stall_cyc   = '0;
  assign flush_cnt   = '0;
  assign memwait_cyc = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed checks of hazard stalls, flushes, dmem waits and timeout.
module tb_pipeline_stall_ctrl;
  logic clk = 0, rst = 1;
  logic MemReadE, PCSrcE, MemAccM, dmem_ready;
  logic [4:0] RD_E, Rs1_D, Rs2_D;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW, mem_err;
  logic [31:0] stall_cyc, flush_cnt, memwait_cyc;
  logic [6:0] outs;
  int n_cmp = 0, n_bad = 0;
  localparam logic [6:0] O_NONE = 7'b0000000, O_LU = 7'b1100010, O_WAIT = 7'b1111001, O_BR = 7'b0000110;

  pipeline_stall_ctrl #(.MAX_WAIT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .MemReadE(MemReadE), .RD_E(RD_E), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
    .PCSrcE(PCSrcE), .MemAccM(MemAccM), .dmem_ready(dmem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .BubbleW(BubbleW), .mem_err(mem_err),
    .stall_cyc(stall_cyc), .flush_cnt(flush_cnt), .memwait_cyc(memwait_cyc));

  always #5 clk = ~clk;
  assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    {MemReadE, PCSrcE, MemAccM, dmem_ready} = '0;
    {RD_E, Rs1_D, Rs2_D} = '0;
  endtask

  task automatic test_reset;
    clr();
    tick();
    tick();
    #2;
    n_cmp++;
    if (outs !== O_NONE || mem_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outs: got %b err %b, want %b err 0", outs, mem_err, O_NONE);
    end
    n_cmp++;
    if ({stall_cyc, flush_cnt, memwait_cyc} !== '0) begin
      n_bad++;
      $display("FAIL reset_cnt: got %0d %0d %0d, want 0 0 0", stall_cyc, flush_cnt, memwait_cyc);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_load_use;
    MemReadE = 1; RD_E = 5; Rs1_D = 5; Rs2_D = 9;
    #2;
    n_cmp++;
    if (outs !== O_LU) begin n_bad++; $display("FAIL lu_rs1: got %b, want %b", outs, O_LU); end
    tick();
    clr();
    #2;
    n_cmp++;
    if (outs !== O_NONE) begin n_bad++; $display("FAIL lu_after: got %b, want %b", outs, O_NONE); end
    tick();
  endtask

  task automatic test_memwait;
    MemAccM = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++;
      if (outs !== O_WAIT) begin n_bad++; $display("FAIL memwait_c%0d: got %b, want %b", i, outs, O_WAIT); end
      tick();
    end
    dmem_ready = 1;
    #2;
    n_cmp++;
    if (outs !== O_NONE) begin n_bad++; $display("FAIL memwait_ready: got %b, want %b", outs, O_NONE); end
    tick();
    #2;
    n_cmp++;
    if (outs !== O_NONE) begin n_bad++; $display("FAIL memacc_ready_run: got %b, want %b", outs, O_NONE); end
  endtask

  task automatic test_counters;
`ifdef PIPE_PERF_CNT_EN
    n_cmp++;
    if (stall_cyc !== 32'd4 || flush_cnt !== 32'd0 || memwait_cyc !== 32'd3) begin
      n_bad++;
      $display("FAIL perf_cnt: got %0d %0d %0d, want 4 0 3", stall_cyc, flush_cnt, memwait_cyc);
    end
`else
    n_cmp++;
    if ({stall_cyc, flush_cnt, memwait_cyc} !== '0) begin
      n_bad++;
      $display("FAIL perf_cnt_off: got %0d %0d %0d, want 0 0 0", stall_cyc, flush_cnt, memwait_cyc);
    end
`endif
    clr();
    tick();
  endtask

  task automatic test_rd0_branch;
    MemReadE = 1; RD_E = 0; Rs1_D = 0; Rs2_D = 0;
    #2;
    n_cmp++;
    if (outs !== O_NONE) begin n_bad++; $display("FAIL rd0_nostall: got %b, want %b", outs, O_NONE); end
    tick();
    RD_E = 7; Rs2_D = 7;
    #2;
    n_cmp++;
    if (outs !== O_LU) begin n_bad++; $display("FAIL lu_rs2: got %b, want %b", outs, O_LU); end
    PCSrcE = 1;
    #2;
    n_cmp++;
    if (outs !== O_BR) begin n_bad++; $display("FAIL branch_over_lu: got %b, want %b", outs, O_BR); end
    tick();
    clr();
    tick();
  endtask

  task automatic test_branch_in_wait;
    MemAccM = 1; dmem_ready = 0; PCSrcE = 1; MemReadE = 1; RD_E = 3; Rs1_D = 3;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_cmp++;
      if (outs !== O_WAIT) begin n_bad++; $display("FAIL br_wait_c%0d: got %b, want %b", i, outs, O_WAIT); end
      tick();
    end
    dmem_ready = 1;
    #2;
    n_cmp++;
    if (outs !== O_BR) begin n_bad++; $display("FAIL br_wait_ready: got %b, want %b", outs, O_BR); end
    tick();
    PCSrcE = 0; dmem_ready = 0;
    tick();
    dmem_ready = 1;
    #2;
    n_cmp++;
    if (outs !== O_LU) begin n_bad++; $display("FAIL lu_wait_ready: got %b, want %b", outs, O_LU); end
    tick();
    clr();
    tick();
  endtask

  task automatic test_timeout;
    MemAccM = 1; dmem_ready = 0;
    for (int i = 0; i < 16; i++) begin
      #2;
      n_cmp++;
      if (outs !== O_WAIT || mem_err !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout_c%0d: got %b err %b, want %b err 0", i, outs, mem_err, O_WAIT);
      end
      tick();
    end
    #2;
    n_cmp++;
    if (outs !== O_WAIT || mem_err !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_err: got %b err %b, want %b err 1", outs, mem_err, O_WAIT);
    end
    dmem_ready = 1;
    tick();
    #2;
    n_cmp++;
    if (outs !== O_WAIT || mem_err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got %b err %b, want %b err 1", outs, mem_err, O_WAIT);
    end
    rst = 1;
    #1;
    n_cmp++;
    if (outs !== O_NONE || mem_err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_in_rst: got %b err %b, want %b err 0", outs, mem_err, O_NONE);
    end
    tick();
    rst = 0;
    clr();
    #2;
    n_cmp++;
    if (outs !== O_NONE || mem_err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_cleared: got %b err %b, want %b err 0", outs, mem_err, O_NONE);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait;
    MemAccM = 1; dmem_ready = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    MemAccM = 0;
    #2;
    n_cmp++;
    if (outs !== O_NONE) begin n_bad++; $display("FAIL rst_mid_wait: got %b, want %b", outs, O_NONE); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_memwait();
    test_counters();
    test_rd0_branch();
    test_branch_in_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
